// File: rtl/axi_lite_xbar.sv
// AXI4-Lite 1-master to 2-slave crossbar: M1 serves the CLINT window, M0 everything else.
// Independent read and write FSMs, one outstanding transaction each.
module axi_lite_xbar #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] CLINT_BASE = 32'ha000_0048,
  parameter int                CLINT_SIZE = 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  // upstream master
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  // memory slave
  output logic [ADDR_W-1:0]   M0_AXI_ARADDR,
  output logic                M0_AXI_ARVALID,
  input  logic                M0_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M0_AXI_RDATA,
  input  logic [1:0]          M0_AXI_RRESP,
  input  logic                M0_AXI_RVALID,
  output logic                M0_AXI_RREADY,
  output logic [ADDR_W-1:0]   M0_AXI_AWADDR,
  output logic                M0_AXI_AWVALID,
  input  logic                M0_AXI_AWREADY,
  output logic [DATA_W-1:0]   M0_AXI_WDATA,
  output logic [DATA_W/8-1:0] M0_AXI_WSTRB,
  output logic                M0_AXI_WVALID,
  input  logic                M0_AXI_WREADY,
  input  logic [1:0]          M0_AXI_BRESP,
  input  logic                M0_AXI_BVALID,
  output logic                M0_AXI_BREADY,
  // CLINT slave
  output logic [ADDR_W-1:0]   M1_AXI_ARADDR,
  output logic                M1_AXI_ARVALID,
  input  logic                M1_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M1_AXI_RDATA,
  input  logic [1:0]          M1_AXI_RRESP,
  input  logic                M1_AXI_RVALID,
  output logic                M1_AXI_RREADY,
  output logic [ADDR_W-1:0]   M1_AXI_AWADDR,
  output logic                M1_AXI_AWVALID,
  input  logic                M1_AXI_AWREADY,
  output logic [DATA_W-1:0]   M1_AXI_WDATA,
  output logic [DATA_W/8-1:0] M1_AXI_WSTRB,
  output logic                M1_AXI_WVALID,
  input  logic                M1_AXI_WREADY,
  input  logic [1:0]          M1_AXI_BRESP,
  input  logic                M1_AXI_BVALID,
  output logic                M1_AXI_BREADY
);

  // One extra bit so a window ending at the top of the address space cannot wrap.
  localparam logic [ADDR_W:0] CLINT_END = {1'b0, CLINT_BASE} + (ADDR_W+1)'(CLINT_SIZE);

  function automatic logic is_clint(input logic [ADDR_W-1:0] a);
    return (a >= CLINT_BASE) && ({1'b0, a} < CLINT_END);
  endfunction

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_t;

  rstate_t             rstate_q;
  logic [ADDR_W-1:0]   raddr_q;
  logic                rsel_q;

  wstate_t             wstate_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                wsel_q;
  logic                aw_done_q, w_done_q;
  logic                aw_done_d, w_done_d;

  logic m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic aw_accept;

  assign m_arready = rsel_q ? M1_AXI_ARREADY : M0_AXI_ARREADY;
  assign m_rvalid  = rsel_q ? M1_AXI_RVALID  : M0_AXI_RVALID;
  assign m_awready = wsel_q ? M1_AXI_AWREADY : M0_AXI_AWREADY;
  assign m_wready  = wsel_q ? M1_AXI_WREADY  : M0_AXI_WREADY;
  assign m_bvalid  = wsel_q ? M1_AXI_BVALID  : M0_AXI_BVALID;

  assign aw_done_d = aw_done_q | m_awready;
  assign w_done_d  = w_done_q  | m_wready;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rsel_q   <= 1'b0;
    end else begin
      case (rstate_q)
        R_IDLE: if (S_AXI_ARVALID) begin
          raddr_q  <= S_AXI_ARADDR;
          rsel_q   <= is_clint(S_AXI_ARADDR);
          rstate_q <= R_ADDR;
        end
        R_ADDR: if (m_arready) rstate_q <= R_DATA;
        R_DATA: if (m_rvalid && S_AXI_RREADY) rstate_q <= R_IDLE;
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wsel_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) begin
          waddr_q   <= S_AXI_AWADDR;
          wdata_q   <= S_AXI_WDATA;
          wstrb_q   <= S_AXI_WSTRB;
          wsel_q    <= is_clint(S_AXI_AWADDR);
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          wstate_q  <= W_REQ;
        end
        W_REQ: begin
          if (aw_done_d && w_done_d) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wstate_q  <= W_RESP;
          end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
          end
        end
        W_RESP: if (m_bvalid && S_AXI_BREADY) wstate_q <= W_IDLE;
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Ready is masked by reset so nothing is accepted while the block is held.
  assign S_AXI_ARREADY = !ARESET && (rstate_q == R_IDLE);
  assign aw_accept     = !ARESET && (wstate_q == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
  assign S_AXI_AWREADY = aw_accept;
  assign S_AXI_WREADY  = aw_accept;

  assign S_AXI_RDATA  = rsel_q ? M1_AXI_RDATA : M0_AXI_RDATA;
  assign S_AXI_RRESP  = rsel_q ? M1_AXI_RRESP : M0_AXI_RRESP;
  assign S_AXI_RVALID = (rstate_q == R_DATA) && m_rvalid;
  assign S_AXI_BRESP  = wsel_q ? M1_AXI_BRESP : M0_AXI_BRESP;
  assign S_AXI_BVALID = (wstate_q == W_RESP) && m_bvalid;

  assign M0_AXI_ARADDR  = raddr_q;
  assign M1_AXI_ARADDR  = raddr_q;
  assign M0_AXI_ARVALID = (rstate_q == R_ADDR) && !rsel_q;
  assign M1_AXI_ARVALID = (rstate_q == R_ADDR) &&  rsel_q;
  assign M0_AXI_RREADY  = (rstate_q == R_DATA) && !rsel_q && S_AXI_RREADY;
  assign M1_AXI_RREADY  = (rstate_q == R_DATA) &&  rsel_q && S_AXI_RREADY;

  assign M0_AXI_AWADDR  = waddr_q;
  assign M1_AXI_AWADDR  = waddr_q;
  assign M0_AXI_WDATA   = wdata_q;
  assign M1_AXI_WDATA   = wdata_q;
  assign M0_AXI_WSTRB   = wstrb_q;
  assign M1_AXI_WSTRB   = wstrb_q;
  assign M0_AXI_AWVALID = (wstate_q == W_REQ) && !wsel_q && !aw_done_q;
  assign M1_AXI_AWVALID = (wstate_q == W_REQ) &&  wsel_q && !aw_done_q;
  assign M0_AXI_WVALID  = (wstate_q == W_REQ) && !wsel_q && !w_done_q;
  assign M1_AXI_WVALID  = (wstate_q == W_REQ) &&  wsel_q && !w_done_q;
  assign M0_AXI_BREADY  = (wstate_q == W_RESP) && !wsel_q && S_AXI_BREADY;
  assign M1_AXI_BREADY  = (wstate_q == W_RESP) &&  wsel_q && S_AXI_BREADY;

endmodule

// File: tb/tb_axi_lite_xbar.sv
// Directed bench for axi_lite_xbar: the bench plays master and both slaves,
// drives on the falling edge and checks 1 time unit later.
module tb_axi_lite_xbar;

  logic        ACLK, ARESET;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_rresp, s_bresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [3:0]  s_wstrb;

  logic [31:0] m_araddr [2];
  logic        m_arvalid[2], m_arready[2];
  logic [31:0] m_rdata  [2];
  logic [1:0]  m_rresp  [2];
  logic        m_rvalid [2], m_rready[2];
  logic [31:0] m_awaddr [2];
  logic        m_awvalid[2], m_awready[2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_wstrb  [2];
  logic        m_wvalid [2], m_wready[2];
  logic [1:0]  m_bresp  [2];
  logic        m_bvalid [2], m_bready[2];

  int checks = 0;
  int failures = 0;
  int m1_aw_hs = 0;
  int m1_w_hs = 0;

  axi_lite_xbar dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_ARADDR(s_araddr), .S_AXI_ARVALID(s_arvalid), .S_AXI_ARREADY(s_arready),
    .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp), .S_AXI_RVALID(s_rvalid), .S_AXI_RREADY(s_rready),
    .S_AXI_AWADDR(s_awaddr), .S_AXI_AWVALID(s_awvalid), .S_AXI_AWREADY(s_awready),
    .S_AXI_WDATA(s_wdata), .S_AXI_WSTRB(s_wstrb), .S_AXI_WVALID(s_wvalid), .S_AXI_WREADY(s_wready),
    .S_AXI_BRESP(s_bresp), .S_AXI_BVALID(s_bvalid), .S_AXI_BREADY(s_bready),
    .M0_AXI_ARADDR(m_araddr[0]), .M0_AXI_ARVALID(m_arvalid[0]), .M0_AXI_ARREADY(m_arready[0]),
    .M0_AXI_RDATA(m_rdata[0]), .M0_AXI_RRESP(m_rresp[0]), .M0_AXI_RVALID(m_rvalid[0]), .M0_AXI_RREADY(m_rready[0]),
    .M0_AXI_AWADDR(m_awaddr[0]), .M0_AXI_AWVALID(m_awvalid[0]), .M0_AXI_AWREADY(m_awready[0]),
    .M0_AXI_WDATA(m_wdata[0]), .M0_AXI_WSTRB(m_wstrb[0]), .M0_AXI_WVALID(m_wvalid[0]), .M0_AXI_WREADY(m_wready[0]),
    .M0_AXI_BRESP(m_bresp[0]), .M0_AXI_BVALID(m_bvalid[0]), .M0_AXI_BREADY(m_bready[0]),
    .M1_AXI_ARADDR(m_araddr[1]), .M1_AXI_ARVALID(m_arvalid[1]), .M1_AXI_ARREADY(m_arready[1]),
    .M1_AXI_RDATA(m_rdata[1]), .M1_AXI_RRESP(m_rresp[1]), .M1_AXI_RVALID(m_rvalid[1]), .M1_AXI_RREADY(m_rready[1]),
    .M1_AXI_AWADDR(m_awaddr[1]), .M1_AXI_AWVALID(m_awvalid[1]), .M1_AXI_AWREADY(m_awready[1]),
    .M1_AXI_WDATA(m_wdata[1]), .M1_AXI_WSTRB(m_wstrb[1]), .M1_AXI_WVALID(m_wvalid[1]), .M1_AXI_WREADY(m_wready[1]),
    .M1_AXI_BRESP(m_bresp[1]), .M1_AXI_BVALID(m_bvalid[1]), .M1_AXI_BREADY(m_bready[1])
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Handshake counters on the CLINT write channels.
  always @(posedge ACLK) begin
    if (m_awvalid[1] && m_awready[1]) m1_aw_hs <= m1_aw_hs + 1;
    if (m_wvalid[1] && m_wready[1])   m1_w_hs  <= m1_w_hs + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] addr, input bit sel1, input logic [31:0] data,
                    input logic [1:0] resp);
    int s, o;
    s = sel1 ? 1 : 0;
    o = 1 - s;
    @(negedge ACLK);
    s_araddr = addr; s_arvalid = 1'b1;
    #1 chk("rd_arready", s_arready, 1);
    @(negedge ACLK);
    s_arvalid = 1'b0; m_arready[s] = 1'b1;
    #1 chk("rd_sel_arvalid", m_arvalid[s], 1);
    chk("rd_other_arvalid", m_arvalid[o], 0);
    chk("rd_araddr", m_araddr[s], addr);
    chk("rd_arready_busy", s_arready, 0);
    @(negedge ACLK);
    m_arready[s] = 1'b0;
    m_rvalid[s] = 1'b1; m_rdata[s] = data;  m_rresp[s] = resp;
    m_rvalid[o] = 1'b1; m_rdata[o] = ~data; m_rresp[o] = ~resp;
    s_rready = 1'b1;
    #1 chk("rd_rvalid", s_rvalid, 1);
    chk("rd_rdata", s_rdata, data);
    chk("rd_rresp", s_rresp, resp);
    chk("rd_sel_rready", m_rready[s], 1);
    chk("rd_other_rready", m_rready[o], 0);
    chk("rd_arvalid_dropped", m_arvalid[s], 0);
    @(negedge ACLK);
    m_rvalid[0] = 1'b0; m_rvalid[1] = 1'b0; s_rready = 1'b0;
    #1 chk("rd_rvalid_idle", s_rvalid, 0);
    chk("rd_arready_idle", s_arready, 1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input bit sel1, input logic [1:0] bresp, input bit aw_first);
    int s, o, a0, w0;
    s = sel1 ? 1 : 0;
    o = 1 - s;
    a0 = m1_aw_hs;
    w0 = m1_w_hs;
    @(negedge ACLK);
    s_awaddr = addr; s_wdata = data; s_wstrb = strb; s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1 chk("wr_awready", s_awready, 1);
    chk("wr_wready", s_wready, 1);
    @(negedge ACLK);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (aw_first) m_awready[s] = 1'b1; else m_wready[s] = 1'b1;
    #1 chk("wr_sel_awvalid", m_awvalid[s], 1);
    chk("wr_sel_wvalid", m_wvalid[s], 1);
    chk("wr_other_awvalid", m_awvalid[o], 0);
    chk("wr_other_wvalid", m_wvalid[o], 0);
    chk("wr_awaddr", m_awaddr[s], addr);
    chk("wr_wdata", m_wdata[s], data);
    chk("wr_wstrb", m_wstrb[s], strb);
    @(negedge ACLK);
    m_awready[s] = !aw_first; m_wready[s] = aw_first;
    #1 chk("wr_awvalid_second", m_awvalid[s], !aw_first);
    chk("wr_wvalid_second", m_wvalid[s], aw_first);
    chk("wr_bvalid_early", s_bvalid, 0);
    @(negedge ACLK);
    m_awready[s] = 1'b0; m_wready[s] = 1'b0;
    m_bvalid[s] = 1'b1; m_bresp[s] = bresp;
    m_bvalid[o] = 1'b1; m_bresp[o] = ~bresp;
    s_bready = 1'b1;
    #1 chk("wr_bvalid", s_bvalid, 1);
    chk("wr_bresp", s_bresp, bresp);
    chk("wr_sel_bready", m_bready[s], 1);
    chk("wr_other_bready", m_bready[o], 0);
    chk("wr_awvalid_resp", m_awvalid[s], 0);
    chk("wr_wvalid_resp", m_wvalid[s], 0);
    @(negedge ACLK);
    m_bvalid[0] = 1'b0; m_bvalid[1] = 1'b0; s_bready = 1'b0;
    #1 chk("wr_bvalid_idle", s_bvalid, 0);
    if (sel1) begin
      chk("wr_m1_aw_handshakes", 64'(m1_aw_hs - a0), 1);
      chk("wr_m1_w_handshakes", 64'(m1_w_hs - w0), 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_arready[i] = 0; m_rdata[i] = 0; m_rresp[i] = 0; m_rvalid[i] = 0;
      m_awready[i] = 0; m_wready[i] = 0; m_bresp[i] = 0; m_bvalid[i] = 0;
    end
    // Valids held high during reset: nothing may be accepted or forwarded.
    ARESET = 1'b1;
    s_araddr = 32'ha000_0048; s_arvalid = 1'b1; s_rready = 1'b1;
    s_awaddr = 32'ha000_0048; s_wdata = 32'h1111_2222; s_wstrb = 4'hf;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    m_rvalid[0] = 1'b1; m_rvalid[1] = 1'b1; m_bvalid[0] = 1'b1; m_bvalid[1] = 1'b1;
    repeat (2) @(negedge ACLK);
    #1 chk("rst_arready", s_arready, 0);
    chk("rst_awready", s_awready, 0);
    chk("rst_wready", s_wready, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_m1_arvalid", m_arvalid[1], 0);
    chk("rst_m0_rready", m_rready[0], 0);
    chk("rst_m1_bready", m_bready[1], 0);
    chk("rst_araddr", m_araddr[0], 0);
    chk("rst_wdata", m_wdata[1], 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    s_arvalid = 0; s_rready = 0; s_awvalid = 0; s_wvalid = 0; s_bready = 0;
    m_rvalid[0] = 0; m_rvalid[1] = 0; m_bvalid[0] = 0; m_bvalid[1] = 0;

    // Reads: CLINT with non-standard RRESP, then decode boundaries.
    rd(32'ha000_0048, 1'b1, 32'h0000_1234, 2'b01);
    rd(32'h8000_0000, 1'b0, 32'hcafe_0001, 2'b00);
    rd(32'ha000_0050, 1'b0, 32'hcafe_0002, 2'b10);
    rd(32'ha000_0047, 1'b0, 32'hcafe_0003, 2'b00);
    rd(32'ha000_004f, 1'b1, 32'h0bad_f00d, 2'b11);

    // Writes: AW accepted first, then W first, then one to memory.
    wr(32'ha000_004c, 32'hdead_beef, 4'hf, 1'b1, 2'b00, 1'b1);
    wr(32'ha000_0048, 32'h0123_4567, 4'h3, 1'b1, 2'b01, 1'b0);
    wr(32'h0000_1000, 32'h89ab_cdef, 4'hc, 1'b0, 2'b10, 1'b1);

    // AW without W is never accepted.
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      s_awaddr = 32'h0000_2000; s_awvalid = 1'b1; s_wvalid = 1'b0;
      #1 chk("aw_only_awready", s_awready, 0);
      chk("aw_only_wready", s_wready, 0);
    end
    wr(32'h0000_2000, 32'h5a5a_5a5a, 4'h1, 1'b0, 2'b00, 1'b0);

    // Concurrent read to M0 and write to M1 with a stalled master.
    @(negedge ACLK);
    s_araddr = 32'h8000_0010; s_arvalid = 1'b1;
    s_awaddr = 32'ha000_004c; s_wdata = 32'h7777_8888; s_wstrb = 4'hf;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1 chk("cc_arready", s_arready, 1);
    chk("cc_awready", s_awready, 1);
    @(negedge ACLK);
    s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
    m_arready[0] = 1; m_awready[1] = 1; m_wready[1] = 1;
    #1 chk("cc_m0_arvalid", m_arvalid[0], 1);
    chk("cc_m1_awvalid", m_awvalid[1], 1);
    chk("cc_m1_wvalid", m_wvalid[1], 1);
    @(negedge ACLK);
    m_arready[0] = 0; m_awready[1] = 0; m_wready[1] = 0;
    m_rvalid[0] = 1; m_rdata[0] = 32'h5555_aaaa; m_rresp[0] = 2'b00;
    m_bvalid[1] = 1; m_bresp[1] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1 chk("cc_rvalid_stall", s_rvalid, 1);
      chk("cc_bvalid_stall", s_bvalid, 1);
      chk("cc_rdata", s_rdata, 32'h5555_aaaa);
      chk("cc_bresp", s_bresp, 2'b01);
      chk("cc_m0_rready_stall", m_rready[0], 0);
      chk("cc_m1_bready_stall", m_bready[1], 0);
      @(negedge ACLK);
    end
    s_rready = 1; s_bready = 1;
    #1 chk("cc_m0_rready", m_rready[0], 1);
    chk("cc_m1_bready", m_bready[1], 1);
    @(negedge ACLK);
    m_rvalid[0] = 0; m_bvalid[1] = 0; s_rready = 0; s_bready = 0;
    #1 chk("cc_rvalid_done", s_rvalid, 0);
    chk("cc_bvalid_done", s_bvalid, 0);
    chk("cc_arready_done", s_arready, 1);

    // Reset pulse while a read sits in the data phase.
    @(negedge ACLK);
    s_araddr = 32'h0000_0040; s_arvalid = 1'b1;
    @(negedge ACLK);
    s_arvalid = 0; m_arready[0] = 1;
    @(negedge ACLK);
    m_arready[0] = 0; m_rvalid[0] = 1; m_rdata[0] = 32'h1357_9bdf; s_rready = 1;
    #1 chk("rr_rvalid_before", s_rvalid, 1);
    chk("rr_rready_before", m_rready[0], 1);
    #1 ARESET = 1'b1;
    #1 chk("rr_rvalid_reset", s_rvalid, 0);
    chk("rr_m0_rready_reset", m_rready[0], 0);
    chk("rr_arready_reset", s_arready, 0);
    @(negedge ACLK);
    ARESET = 1'b0; m_rvalid[0] = 0; s_rready = 0;
    #1 chk("rr_m0_arvalid_after", m_arvalid[0], 0);
    chk("rr_rvalid_after", s_rvalid, 0);
    rd(32'h0000_0044, 1'b0, 32'h2468_ace0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_xbar.md
AXI_LITE_XBAR -- requirements
Module: axi_lite_xbar

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-003 SHALL have parameter CLINT_BASE, default 32'ha000_0048, CLINT window base.
REQ-004 SHALL have parameter CLINT_SIZE, default 8, CLINT window size in bytes.
REQ-005 Each port line SHALL read: name, direction, width, meaning. M{0,1} means the port exists once for M0 (memory slave) and once for M1 (CLINT slave).
REQ-006 ACLK  in  1  single clock; all logic on rising edge.
REQ-007 ARESET  in  1  asynchronous, active-high reset.
REQ-008 S_AXI_ARADDR / M{0,1}_AXI_ARADDR  in / out  ADDR_W  read address.
REQ-009 S_AXI_ARVALID / M{0,1}_AXI_ARVALID  in / out  1  read address valid.
REQ-010 S_AXI_ARREADY / M{0,1}_AXI_ARREADY  out / in  1  read address ready.
REQ-011 S_AXI_RDATA / M{0,1}_AXI_RDATA  out / in  DATA_W  read data.
REQ-012 S_AXI_RRESP / M{0,1}_AXI_RRESP  out / in  2  read response.
REQ-013 S_AXI_RVALID / M{0,1}_AXI_RVALID  out / in  1  read data valid.
REQ-014 S_AXI_RREADY / M{0,1}_AXI_RREADY  in / out  1  read data ready.
REQ-015 S_AXI_AWADDR / M{0,1}_AXI_AWADDR  in / out  ADDR_W  write address.
REQ-016 S_AXI_AWVALID / M{0,1}_AXI_AWVALID  in / out  1  write address valid.
REQ-017 S_AXI_AWREADY / M{0,1}_AXI_AWREADY  out / in  1  write address ready.
REQ-018 S_AXI_WDATA / M{0,1}_AXI_WDATA  in / out  DATA_W  write data.
REQ-019 S_AXI_WSTRB / M{0,1}_AXI_WSTRB  in / out  DATA_W/8  byte strobes.
REQ-020 S_AXI_WVALID / M{0,1}_AXI_WVALID  in / out  1  write data valid.
REQ-021 S_AXI_WREADY / M{0,1}_AXI_WREADY  out / in  1  write data ready.
REQ-022 S_AXI_BRESP / M{0,1}_AXI_BRESP  out / in  2  write response.
REQ-023 S_AXI_BVALID / M{0,1}_AXI_BVALID  out / in  1  write response valid.
REQ-024 S_AXI_BREADY / M{0,1}_AXI_BREADY  in / out  1  write response ready.

Function
REQ-025 Decode SHALL select M1 when CLINT_BASE <= addr < CLINT_BASE+CLINT_SIZE. All other addresses, including CLINT_BASE+CLINT_SIZE, SHALL select M0.
REQ-026 Read and write paths SHALL be independent FSMs, each allowing one outstanding transaction, and SHALL run concurrently.
REQ-027 Read FSM states SHALL be R_IDLE, R_ADDR, R_DATA.
REQ-028 S_AXI_ARREADY SHALL equal (state==R_IDLE). On ARVALID&&ARREADY the block SHALL latch address and select, then go to R_ADDR.
REQ-029 In R_ADDR, selected M ARVALID=1 with the latched address, starting the cycle after S acceptance. On M ARREADY the FSM SHALL go to R_DATA.
REQ-030 In R_DATA, selected M RDATA/RRESP/RVALID SHALL pass combinationally to S, and S RREADY SHALL pass to selected M RREADY. On RVALID&&RREADY the FSM SHALL return to R_IDLE.
REQ-031 Write FSM states SHALL be W_IDLE, W_REQ, W_RESP.
REQ-032 S_AXI_AWREADY and S_AXI_WREADY SHALL both equal (state==W_IDLE && AWVALID && WVALID). AW alone or W alone SHALL NOT be accepted.
REQ-033 On acceptance the block SHALL latch AWADDR, WDATA, WSTRB and select, then go to W_REQ.
REQ-034 In W_REQ, selected M AWVALID and WVALID SHALL each stay high until their own handshake, tracked by aw_done and w_done flags in either order. When both are done the FSM SHALL go to W_RESP.
REQ-035 In W_RESP, selected M BRESP/BVALID SHALL pass to S, and S BREADY SHALL pass to M. On BVALID&&BREADY the FSM SHALL return to W_IDLE.
REQ-036 RRESP and BRESP SHALL pass unmodified, including the non-standard value 2'b01.
REQ-037 The unselected slave SHALL see all VALID and READY outputs at 0. S RVALID/BVALID SHALL be 0 outside R_DATA/W_RESP.
REQ-038 Minimum latency SHALL be: S AR accept at cycle 0, M ARVALID at cycle 1, S RVALID in the same cycle as M RVALID.

Reset
REQ-039 While ARESET=1: both FSMs idle, aw_done=w_done=0, all M VALID/READY outputs 0, S ARREADY/AWREADY/WREADY/RVALID/BVALID 0, latched address/data 0.
REQ-040 Reset asserted mid-transaction SHALL abandon the transaction with no further VALID on any port.

Verification
REQ-041 Read 0xa000_0048; M1 ARREADY=1, then RDATA=0x1234, RRESP=01 -> S RDATA=0x1234, RRESP=01; M0 sees no ARVALID.
REQ-042 Read 0x8000_0000 and 0xa000_0050 -> both routed to M0; M1 stays idle.
REQ-043 Write 0xa000_004c, WDATA=0xdead_beef, WSTRB=4'hf; M1 AWREADY one cycle before WREADY -> exactly one handshake each, then S BVALID follows M1 BVALID.
REQ-044 AWVALID=1 with WVALID=0 for 5 cycles -> S AWREADY=0 throughout; WVALID=1 -> accept in that cycle.
REQ-045 Concurrent read to M0 and write to M1, with S RREADY/BREADY held 0 for 3 cycles -> both complete correctly and S VALIDs stay high until their handshakes.
REQ-046 ARESET pulse during R_DATA -> M RREADY=0 and S RVALID=0 immediately; the next read completes normally.
